// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing a single-ported synchronous-read memory between
// instruction fetch and data load/store, with round-robin tie breaking.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t              state_q, state_d;
  grant_t              gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        // Instruction wins when alone, or on a tie when data was served last.
        if (i_req && (!d_req || gnt_q == GNT_D)) begin
          gnt_d   = GNT_I;
          addr_d  = i_addr;
          we_d    = 1'b0;
          state_d = S_ACCESS;
        end else if (d_req) begin
          gnt_d   = GNT_D;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_we;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = LAT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = 3'(cnt_q - 3'd1);
        if (cnt_q == 3'd1) begin
          if (gnt_q == GNT_I) i_rdata_d = mem_q;
          else                d_rdata_d = mem_q;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= GNT_D;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Reset gates the write strobe so a store aborted in its ACCESS cycle never lands.
  assign mem_wr_en = (state_q == S_ACCESS) && we_q && !Reset;
  assign mem_addr  = addr_q;
  assign mem_data  = wdata_q;
  assign i_ack     = (state_q == S_RESP) && (gnt_q == GNT_I);
  assign d_ack     = (state_q == S_RESP) && (gnt_q == GNT_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected acks are queued by the stimulus, a negedge
// monitor pops and checks them; a second instance covers RD_LAT=3.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_init = 1'b1;
  int          cyc = 0;

  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [5:0]  i_addr = '0, d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        i_ack, d_ack, mem_wr_en, busy;
  logic [15:0] i_rdata, d_rdata, mem_data;
  logic [15:0] mem_q;
  logic [5:0]  mem_addr;
  logic [15:0] mem [64];

  logic        i2_req = 1'b0;
  logic [5:0]  i2_addr = '0;
  logic        i2_ack, d2_ack, mem2_wr_en, busy2;
  logic [15:0] i2_rdata, d2_rdata, mem2_data, mem2_q;
  logic [5:0]  mem2_addr;

  int checks = 0;
  int failures = 0;
  logic [15:0] last_i = '0, last_d = '0;

  typedef struct {
    int          port;   // 0 = instruction, 1 = data
    logic        rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) mem[k] <= 16'(k * 16'h0111);
      mem[2] <= 16'h1234;
      mem[3] <= 16'h0000;
      mem[4] <= 16'h0A0B;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_data;
    end
    mem_q <= mem[mem_addr];
  end

  assign mem2_q = 16'hC000 + cyc[15:0];

  mem_port_arbiter u_dut (
    .Clock(clk), .Reset(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
    .mem_q(mem_q), .busy(busy)
  );

  mem_port_arbiter #(.RD_LAT(3)) u_dut3 (
    .Clock(clk), .Reset(rst),
    .i_req(i2_req), .i_addr(i2_addr), .i_ack(i2_ack), .i_rdata(i2_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(6'd0), .d_wdata(16'h0000),
    .d_ack(d2_ack), .d_rdata(d2_rdata),
    .mem_addr(mem2_addr), .mem_data(mem2_data), .mem_wr_en(mem2_wr_en),
    .mem_q(mem2_q), .busy(busy2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int port, input logic rd, input logic [15:0] data, input int c);
    exp_t e;
    e.port = port; e.rd = rd; e.data = data; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drv_d(input logic we, input logic [5:0] a, input logic [15:0] wd);
    int n = 0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    do begin @(negedge clk); n++; end while (!d_ack && n < 40);
    if (!d_ack) begin
      checks++; failures++;
      $display("FAIL d_ack_timeout: got no ack in 40 cycles expected ack");
    end
    d_req = 1'b0;
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_ack && d_ack) begin
        checks++; failures++;
        $display("FAIL dual_ack: got i_ack=1 d_ack=1 expected one");
      end else if (i_ack || d_ack) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("ack_port", d_ack ? 1 : 0, e.port);
          if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
          if (e.port == 0) begin
            chk("i_rdata", int'(i_rdata), int'(e.data));
            last_i = e.data;
            chk("d_rdata_untouched", int'(d_rdata), int'(last_d));
          end else begin
            if (e.rd) begin
              chk("d_rdata", int'(d_rdata), int'(e.data));
              last_d = e.data;
            end else begin
              chk("d_rdata_hold_on_store", int'(d_rdata), int'(last_d));
            end
            chk("i_rdata_untouched", int'(i_rdata), int'(last_i));
          end
        end
      end
    end
  end

  initial begin
    int c, n;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_data", int'(mem_data), 0);
    chk("rst_i_rdata", int'(i_rdata), 0);
    chk("rst_d_rdata", int'(d_rdata), 0);
    rst = 1'b0;

    // Instruction read of address 4.
    @(negedge clk);
    c = cyc;
    push(0, 1'b1, 16'h0A0B, c + 3);
    i_req = 1'b1; i_addr = 6'd4;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_busy", busy, (k <= 3) ? 1 : 0);
      chk("t1_wr_en", mem_wr_en, 0);
      if (k == 3) i_req = 1'b0;
    end

    // Store 0x0004 to address 3, then load it back.
    c = cyc;
    push(1, 1'b0, 16'h0000, c + 2);
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd3; d_wdata = 16'h0004;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t2_wr_en", mem_wr_en, (k == 1) ? 1 : 0);
      if (k == 1) begin
        chk("t2_mem_addr", int'(mem_addr), 3);
        chk("t2_mem_data", int'(mem_data), 16'h0004);
      end
      if (k == 2) d_req = 1'b0;
    end
    c = cyc;
    push(1, 1'b1, 16'h0004, c + 3);
    drv_d(1'b0, 6'd3, 16'h0000);
    @(negedge clk);

    // Reset, then both ports request continuously: I, D, I, D.
    rst = 1'b1; last_i = '0; last_d = '0;
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    push(0, 1'b1, 16'h0A0B, c + 3);
    push(1, 1'b1, 16'h0004, c + 7);
    push(0, 1'b1, 16'h0A0B, c + 11);
    push(1, 1'b1, 16'h0004, c + 15);
    i_req = 1'b1; i_addr = 6'd4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd3;
    repeat (15) @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);

    // Data request arrives during instruction WAIT.
    c = cyc;
    push(0, 1'b1, 16'h0A0B, c + 3);
    push(1, 1'b1, 16'h1234, c + 7);
    i_req = 1'b1; i_addr = 6'd4;
    repeat (2) @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd2;
    @(negedge clk);
    i_req = 1'b0;
    repeat (4) @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);

    // Reset in the ACCESS cycle of a store of 0xFFFF to address 2.
    c = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd2; d_wdata = 16'hFFFF;
    @(negedge clk);
    rst = 1'b1; last_i = '0; last_d = '0;
    #1 chk("t5_wr_en_suppressed", mem_wr_en, 0);
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_mem_addr", int'(mem_addr), 0);
    chk("t5_mem_data", int'(mem_data), 0);
    chk("t5_d_rdata", int'(d_rdata), 0);
    chk("t5_mem2_kept", int'(mem[2]), 16'h1234);
    rst = 1'b0;
    push(1, 1'b0, 16'h0000, c + 4);
    repeat (2) @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    chk("t5_mem2_written", int'(mem[2]), 16'hFFFF);
    c = cyc;
    push(1, 1'b1, 16'hFFFF, c + 3);
    drv_d(1'b0, 6'd2, 16'h0000);
    @(negedge clk);

    // RD_LAT=3 instance: capture happens 3 cycles after ACCESS.
    c = cyc;
    i2_req = 1'b1; i2_addr = 6'd9;
    n = 0;
    do begin @(negedge clk); n++; end while (!i2_ack && n < 40);
    chk("t6_ack_cycle", i2_ack ? cyc : -1, c + 5);
    chk("t6_i_rdata", int'(i2_rdata), int'(16'(16'hC000 + c + 4)));
    i2_req = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
